// File: rtl/subpel_row_filter_pkg.sv
// Shared constants for the sub-pel row filter: filter select codes, HEVC luma taps and the
// row/array geometry also used by input_array_mux.
package subpel_row_filter_pkg;

  localparam int ROWS      = 15;
  localparam int OUTS      = ROWS - 7;
  localparam int TAPS      = 8;
  localparam int PIX_W     = 8;
  localparam int ROUND_SH  = 6;
  localparam int SUM_W     = 17;
  localparam int ROW_W     = ROWS * PIX_W;
  localparam int ROW_OUT_W = OUTS * PIX_W;
  localparam int ARRAY_W   = ROWS * ROW_OUT_W;
  localparam int ROW_IDX_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    FILT_A    = 2'd0,
    FILT_B    = 2'd1,
    FILT_C    = 2'd2,
    FILT_COPY = 2'd3
  } filt_e;

  // Tap j sits at [8j +: 8], two's complement.
  localparam logic [TAPS*8-1:0] TAPS_A = {8'h00, 8'h01, 8'hfb, 8'h11, 8'h3a, 8'hf6, 8'h04, 8'hff};
  localparam logic [TAPS*8-1:0] TAPS_B = {8'hff, 8'h04, 8'hf5, 8'h28, 8'h28, 8'hf5, 8'h04, 8'hff};
  localparam logic [TAPS*8-1:0] TAPS_C = {8'hff, 8'h04, 8'hf6, 8'h3a, 8'h11, 8'hfb, 8'h01, 8'h00};

  typedef struct packed {
    logic [ROW_W-1:0] row;
    filt_e            filt;
  } row_req_t;

  function automatic logic signed [SUM_W-1:0] tap_prod(input filt_e filt, input int j,
                                                       input logic [PIX_W-1:0] pix);
    logic [7:0] coef;
    case (filt)
      FILT_A:  coef = TAPS_A[8*j +: 8];
      FILT_B:  coef = TAPS_B[8*j +: 8];
      FILT_C:  coef = TAPS_C[8*j +: 8];
      default: coef = 8'h00;
    endcase
    return signed'({{(SUM_W-8){coef[7]}}, coef}) * signed'({{(SUM_W-PIX_W){1'b0}}, pix});
  endfunction

endpackage

// File: rtl/fir8_tap.sv
// One HEVC luma sub-pixel: products and two partial sums in S2, final add/round/clip in S3.
// res is valid two cycles after en_s2; no backpressure, each stage loads only on its enable.
module fir8_tap
  import subpel_row_filter_pkg::*;
(
  input  logic                  clock,
  input  logic                  en_s2,
  input  logic                  en_s3,
  input  logic [TAPS*PIX_W-1:0] win,
  input  filt_e                 filt,
  output logic [PIX_W-1:0]      res
);

  localparam logic signed [SUM_W-1:0] RND_BIAS = SUM_W'(2 ** (ROUND_SH - 1));
  localparam logic signed [SUM_W-1:0] PIX_MAX  = SUM_W'((2 ** PIX_W) - 1);

  logic signed [SUM_W-1:0] lo_sum_d, lo_sum_q;
  logic signed [SUM_W-1:0] hi_sum_d, hi_sum_q;
  logic [PIX_W-1:0]        copy_pix_d, copy_pix_q;
  logic                    is_copy_d, is_copy_q;
  logic [PIX_W-1:0]        res_d, res_q;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] rounded;

  always_comb begin : s2_c
    lo_sum_d   = lo_sum_q;
    hi_sum_d   = hi_sum_q;
    copy_pix_d = copy_pix_q;
    is_copy_d  = is_copy_q;
    if (en_s2) begin
      lo_sum_d = '0;
      hi_sum_d = '0;
      for (int j = 0; j < TAPS/2; j++) begin
        lo_sum_d = lo_sum_d + tap_prod(filt, j, win[j*PIX_W +: PIX_W]);
        hi_sum_d = hi_sum_d + tap_prod(filt, j + TAPS/2, win[(j+TAPS/2)*PIX_W +: PIX_W]);
      end
      // Full-pel copy takes the centre pixel but still rides the arithmetic pipeline.
      copy_pix_d = win[3*PIX_W +: PIX_W];
      is_copy_d  = (filt == FILT_COPY);
    end
  end

  always_comb begin : s3_c
    sum     = lo_sum_q + hi_sum_q;
    rounded = (sum + RND_BIAS) >>> ROUND_SH;
    res_d   = res_q;
    if (en_s3) begin
      if (is_copy_q) begin
        res_d = copy_pix_q;
      end else if (rounded[SUM_W-1]) begin
        res_d = '0;
      end else if (rounded > PIX_MAX) begin
        res_d = '1;
      end else begin
        res_d = rounded[PIX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    lo_sum_q   <= lo_sum_d;
    hi_sum_q   <= hi_sum_d;
    copy_pix_q <= copy_pix_d;
    is_copy_q  <= is_copy_d;
    res_q      <= res_d;
  end

  assign res = res_q;

endmodule

// File: rtl/subpel_row_filter.sv
// Filters 15-pixel rows into 8 sub-pixels each and packs 15 rows into one array; a row lands 3 cycles after accept.
// in_ready drops after 15 accepts and while the finished array waits for array_ack; the pipeline itself never stalls.
module subpel_row_filter
  import subpel_row_filter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROW_W-1:0]   in_row,
  input  logic [1:0]         in_filt,
  output logic [ARRAY_W-1:0] array_out,
  output logic               array_valid,
  input  logic               array_ack
);

  logic                 accept;
  logic                 ack_take;
  row_req_t             s1_req_d, s1_req_q;
  logic                 s1_vld_d, s1_vld_q;
  logic                 s2_vld_d, s2_vld_q;
  logic                 s3_vld_d, s3_vld_q;
  logic [ROW_OUT_W-1:0] row_res;
  logic [ARRAY_W-1:0]   array_d, array_q;
  logic [ROW_IDX_W-1:0] wr_row_d, wr_row_q;
  logic [ROW_IDX_W-1:0] acc_cnt_d, acc_cnt_q;
  logic                 last_wr_d, last_wr_q;
  logic                 array_valid_d, array_valid_q;
  logic                 in_ready_d, in_ready_q;

  assign accept   = in_valid & in_ready_q;
  assign ack_take = array_ack & array_valid_q;

  always_comb begin : pipe_c
    s1_vld_d = accept;
    s1_req_d = s1_req_q;
    if (accept) begin
      s1_req_d = '{row: in_row, filt: filt_e'(in_filt)};
    end
    s2_vld_d = s1_vld_q;
    s3_vld_d = s2_vld_q;
  end

  for (genvar k = 0; k < OUTS; k++) begin : g_tap
    fir8_tap u_tap (
      .clock (clock),
      .en_s2 (s1_vld_q),
      .en_s3 (s2_vld_q),
      .win   (s1_req_q.row[k*PIX_W +: TAPS*PIX_W]),
      .filt  (s1_req_q.filt),
      .res   (row_res[k*PIX_W +: PIX_W])
    );
  end

  always_comb begin : write_c
    array_d   = array_q;
    wr_row_d  = wr_row_q;
    last_wr_d = 1'b0;
    if (s3_vld_q) begin
      for (int r = 0; r < ROWS; r++) begin
        if (wr_row_q == ROW_IDX_W'(r)) begin
          array_d[r*ROW_OUT_W +: ROW_OUT_W] = row_res;
        end
      end
      last_wr_d = (wr_row_q == ROW_IDX_W'(ROWS - 1));
      wr_row_d  = last_wr_d ? '0 : wr_row_q + 1'b1;
    end
  end

  // acc_cnt caps a fill at 15 rows, so nothing can overwrite the array while it is held.
  always_comb begin : hs_c
    acc_cnt_d = acc_cnt_q;
    if (ack_take) begin
      acc_cnt_d = '0;
    end else if (accept) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
    array_valid_d = array_valid_q;
    if (ack_take) begin
      array_valid_d = 1'b0;
    end else if (last_wr_q) begin
      array_valid_d = 1'b1;
    end
    in_ready_d = (acc_cnt_d < ROW_IDX_W'(ROWS)) & ~array_valid_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_req_q      <= '0;
      s1_vld_q      <= 1'b0;
      s2_vld_q      <= 1'b0;
      s3_vld_q      <= 1'b0;
      array_q       <= '0;
      wr_row_q      <= '0;
      acc_cnt_q     <= '0;
      last_wr_q     <= 1'b0;
      array_valid_q <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      s1_req_q      <= s1_req_d;
      s1_vld_q      <= s1_vld_d;
      s2_vld_q      <= s2_vld_d;
      s3_vld_q      <= s3_vld_d;
      array_q       <= array_d;
      wr_row_q      <= wr_row_d;
      acc_cnt_q     <= acc_cnt_d;
      last_wr_q     <= last_wr_d;
      array_valid_q <= array_valid_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign array_out   = array_q;
  assign array_valid = array_valid_q;

endmodule

// File: tb/tb_subpel_row_filter.sv
// Bench for subpel_row_filter: directed and random rows against a plain-arithmetic HEVC filter model.
module tb_subpel_row_filter;
  import subpel_row_filter_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [ROW_W-1:0]   in_row;
  logic [1:0]         in_filt;
  logic [ARRAY_W-1:0] array_out;
  logic               array_valid;
  logic               array_ack;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int tap_tbl [3][8] = '{'{-1, 4, -10, 58, 17, -5, 1, 0},
                         '{-1, 4, -11, 40, 40, -11, 4, -1},
                         '{0, 1, -5, 17, 58, -10, 4, -1}};

  logic [ROW_W-1:0]   cur_rows [15];
  logic [1:0]         cur_filt [15];
  logic [ARRAY_W-1:0] exp_array;

  always #5 clock = ~clock;

  subpel_row_filter dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .in_filt     (in_filt),
    .array_out   (array_out),
    .array_valid (array_valid),
    .array_ack   (array_ack)
  );

  function automatic logic [7:0] ref_sub(input logic [ROW_W-1:0] row, input logic [1:0] f, input int k);
    int s;
    int r;
    if (f == 2'd3) return row[8*(k+3) +: 8];
    s = 0;
    for (int j = 0; j < 8; j++) s += tap_tbl[f][j] * int'(row[8*(k+j) +: 8]);
    r = (s + 32) >>> 6;
    if (r < 0) r = 0;
    else if (r > 255) r = 255;
    return r[7:0];
  endfunction

  function automatic logic [ARRAY_W-1:0] ref_array();
    logic [ARRAY_W-1:0] a;
    a = '0;
    for (int r = 0; r < 15; r++)
      for (int k = 0; k < 8; k++)
        a[64*r + 8*k +: 8] = ref_sub(cur_rows[r], cur_filt[r], k);
    return a;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] row;
    for (int p = 0; p < 15; p++) row[8*p +: 8] = 8'($urandom);
    return row;
  endfunction

  function automatic logic [ROW_W-1:0] ramp_row();
    logic [ROW_W-1:0] row;
    for (int p = 0; p < 15; p++) row[8*p +: 8] = 8'(10 * p);
    return row;
  endfunction

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic push_row(input logic [ROW_W-1:0] row, input logic [1:0] f, output int acc_at);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_row   = row;
    in_filt  = f;
    while (in_ready !== 1'b1 && budget < 40) begin
      tick();
      budget++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got %b want 1", in_ready);
      acc_at = -100;
    end else begin
      tick();
      acc_at = cyc;
    end
  endtask

  task automatic fill_array(input string name, input int hold, input int idle_ack_at);
    logic [ARRAY_W-1:0]   want;
    logic [ROW_OUT_W-1:0] old14, new14;
    int acc_last, seen, budget, bad;
    logic stable;
    want  = ref_array();
    old14 = exp_array[14*ROW_OUT_W +: ROW_OUT_W];
    new14 = want[14*ROW_OUT_W +: ROW_OUT_W];
    acc_last = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == idle_ack_at) begin
        in_valid  = 1'b0;
        array_ack = 1'b1;
        tick();
        array_ack = 1'b0;
      end
      push_row(cur_rows[i], cur_filt[i], acc_last);
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_15: got %b want 0", name, in_ready);
    end
    if (old14 != new14) begin
      seen = -1;
      for (int n = 0; n < 6 && seen < 0; n++) begin
        tick();
        if (array_out[14*ROW_OUT_W +: ROW_OUT_W] === new14) seen = cyc - acc_last;
      end
      checks++;
      if (seen != 3) begin
        errors++;
        $display("FAIL %s latency: got %0d want 3", name, seen);
      end
    end
    budget = 0;
    while (array_valid !== 1'b1 && budget < 12) begin
      tick();
      budget++;
    end
    checks++;
    if (array_valid !== 1'b1 || cyc - acc_last != 4) begin
      errors++;
      $display("FAIL %s valid_timing: valid %b after %0d cycles want 1 after 4", name, array_valid, cyc - acc_last);
    end
    checks++;
    if (array_out !== want) begin
      errors++;
      bad = 0;
      for (int r = 14; r >= 0; r--)
        if (array_out[r*ROW_OUT_W +: ROW_OUT_W] !== want[r*ROW_OUT_W +: ROW_OUT_W]) bad = r;
      $display("FAIL %s content: row %0d got %h want %h", name, bad,
               array_out[bad*ROW_OUT_W +: ROW_OUT_W], want[bad*ROW_OUT_W +: ROW_OUT_W]);
    end
    exp_array = want;
    if (hold > 0) begin
      stable = 1'b1;
      for (int n = 0; n < hold; n++) begin
        tick();
        if (array_valid !== 1'b1 || in_ready !== 1'b0 || array_out !== want) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
        errors++;
        $display("FAIL %s hold: valid=%b ready=%b want valid=1 ready=0 array frozen", name, array_valid, in_ready);
      end
    end
    array_ack = 1'b1;
    tick();
    array_ack = 1'b0;
    checks++;
    if (array_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ack: valid=%b ready=%b want valid=0 ready=1", name, array_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; array_ack = 1'b0; in_row = '0; in_filt = 2'd0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || array_valid !== 1'b0 || array_out !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b out_zero=%b want 0 0 1", in_ready, array_valid, array_out == '0);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || array_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b want 1 0", in_ready, array_valid);
    end
    exp_array = '0;
  endtask

  task automatic test_constant();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 15; i++) begin
        cur_rows[i] = {15{8'd100}};
        cur_filt[i] = 2'(f);
      end
      fill_array($sformatf("const_f%0d", f), 0, -1);
      checks++;
      if (array_out !== {120{8'h64}}) begin
        errors++;
        $display("FAIL const_f%0d bytes: row0 got %h want all 64", f, array_out[63:0]);
      end
    end
  endtask

  task automatic test_ramp(input logic [1:0] f, input int base, input string name);
    logic ok;
    for (int i = 0; i < 15; i++) begin
      cur_rows[i] = ramp_row();
      cur_filt[i] = f;
    end
    fill_array(name, 2, -1);
    ok = 1'b1;
    for (int r = 0; r < 15; r++)
      for (int k = 0; k < 8; k++)
        if (array_out[64*r + 8*k +: 8] !== 8'(base + 10*k)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s bytes: row0 got %h want base %0d step 10", name, array_out[63:0], base);
    end
  endtask

  task automatic test_clip();
    logic [ROW_W-1:0] row;
    row = '0;
    row[24 +: 8] = 8'd255;
    row[32 +: 8] = 8'd255;
    for (int i = 0; i < 15; i++) begin
      cur_rows[i] = row;
      cur_filt[i] = 2'd1;
    end
    fill_array("clip", 0, 5);
    checks++;
    if (array_out[7:0] !== 8'd255 || array_out[15:8] !== 8'd116 || array_out[23:16] !== 8'd0) begin
      errors++;
      $display("FAIL clip bytes: k0..2 got %0d %0d %0d want 255 116 0",
               array_out[7:0], array_out[15:8], array_out[23:16]);
    end
  endtask

  task automatic test_handshake();
    logic [ROW_W-1:0]   rows [30];
    logic [1:0]         fl [30];
    logic [ARRAY_W-1:0] want;
    int accepted, budget;
    logic stable;
    for (int i = 0; i < 30; i++) begin
      rows[i] = rand_row();
      fl[i]   = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 15; i++) begin
      cur_rows[i] = rows[i];
      cur_filt[i] = fl[i];
    end
    want     = ref_array();
    accepted = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      in_row  = rows[accepted];
      in_filt = fl[accepted];
      if (in_ready === 1'b1) accepted++;
      tick();
    end
    checks++;
    if (accepted != 15) begin
      errors++;
      $display("FAIL hs_accept_count: got %0d want 15", accepted);
    end
    in_row  = rows[15];
    in_filt = fl[15];
    budget  = 0;
    while (array_valid !== 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    checks++;
    if (array_valid !== 1'b1 || array_out !== want) begin
      errors++;
      $display("FAIL hs_array: valid=%b row0 got %h want %h", array_valid, array_out[63:0], want[63:0]);
    end
    exp_array = want;
    stable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (in_ready !== 1'b0 || array_valid !== 1'b1 || array_out !== want) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hs_hold: ready=%b valid=%b want 0 1 with array frozen", in_ready, array_valid);
    end
    array_ack = 1'b1;
    tick();
    array_ack = 1'b0;
    checks++;
    if (array_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_ack: valid=%b ready=%b want 0 1", array_valid, in_ready);
    end
    for (int i = 0; i < 15; i++) begin
      cur_rows[i] = rows[15 + i];
      cur_filt[i] = fl[15 + i];
    end
    fill_array("hs_second", 0, -1);
  endtask

  task automatic test_reset_mid();
    int acc;
    for (int i = 0; i < 7; i++) push_row(rand_row(), 2'($urandom_range(0, 3)), acc);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0 || array_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_during: ready=%b valid=%b want 0 0", in_ready, array_valid);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || array_valid !== 1'b0 || array_out !== '0) begin
      errors++;
      $display("FAIL rst_mid_after: ready=%b valid=%b out_zero=%b want 1 0 1", in_ready, array_valid, array_out == '0);
    end
    exp_array = '0;
    for (int i = 0; i < 15; i++) begin
      cur_rows[i] = rand_row();
      cur_filt[i] = 2'($urandom_range(0, 3));
    end
    fill_array("rst_mid_fill", 0, -1);
  endtask

  task automatic test_random();
    for (int a = 0; a < 4; a++) begin
      for (int i = 0; i < 15; i++) begin
        cur_rows[i] = rand_row();
        cur_filt[i] = 2'($urandom_range(0, 3));
      end
      fill_array($sformatf("random%0d", a), $urandom_range(0, 3), $urandom_range(1, 20));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_constant();
    test_ramp(2'd1, 35, "ramp_b");
    test_ramp(2'd3, 30, "ramp_copy");
    test_clip();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
